ex_muldiv_stage: RTL and testbench

//  Parametrised MIPS execute stage: single-cycle logic/shift/arith ALU plus HI/LO registers,

---
 rtl/ex_muldiv_stage.sv | 213 +++++++++++++++++++++
 tb/tb_ex_muldiv_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_stage.sv
// MIPS execute stage: single-cycle ALU, HI/LO registers, combinational
// multiply and an iterative restoring divider that stalls the pipeline.
module ex_muldiv_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8,
    parameter int ALUSEL_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [ALUSEL_W-1:0]   alusel_in,
    input  logic [ALUOP_W-1:0]    aluop_in,
    input  logic [DATA_W-1:0]     reg1_in,
    input  logic [DATA_W-1:0]     reg2_in,
    input  logic [REG_ADDR_W-1:0] w_reg_addr_in,
    input  logic                  w_reg_en_in,
    output logic [REG_ADDR_W-1:0] w_reg_addr_out,
    output logic [DATA_W-1:0]     w_reg_data_out,
    output logic                  w_reg_en_out,
    output logic                  ovf_out,
    output logic                  stall_req,
    output logic [DATA_W-1:0]     hi_out,
    output logic [DATA_W-1:0]     lo_out
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    localparam logic [ALUOP_W-1:0] EXE_AND   = ALUOP_W'(8'b00100100);
    localparam logic [ALUOP_W-1:0] EXE_OR    = ALUOP_W'(8'b00100101);
    localparam logic [ALUOP_W-1:0] EXE_XOR   = ALUOP_W'(8'b00100110);
    localparam logic [ALUOP_W-1:0] EXE_NOR   = ALUOP_W'(8'b00100111);
    localparam logic [ALUOP_W-1:0] EXE_SLL   = ALUOP_W'(8'b01111100);
    localparam logic [ALUOP_W-1:0] EXE_SRL   = ALUOP_W'(8'b00000010);
    localparam logic [ALUOP_W-1:0] EXE_SRA   = ALUOP_W'(8'b00000011);
    localparam logic [ALUOP_W-1:0] EXE_SLT   = ALUOP_W'(8'b00101010);
    localparam logic [ALUOP_W-1:0] EXE_SLTU  = ALUOP_W'(8'b00101011);
    localparam logic [ALUOP_W-1:0] EXE_ADD   = ALUOP_W'(8'b00100000);
    localparam logic [ALUOP_W-1:0] EXE_ADDU  = ALUOP_W'(8'b00100001);
    localparam logic [ALUOP_W-1:0] EXE_SUB   = ALUOP_W'(8'b00100010);
    localparam logic [ALUOP_W-1:0] EXE_SUBU  = ALUOP_W'(8'b00100011);
    localparam logic [ALUOP_W-1:0] EXE_MULT  = ALUOP_W'(8'b00011000);
    localparam logic [ALUOP_W-1:0] EXE_MULTU = ALUOP_W'(8'b00011001);
    localparam logic [ALUOP_W-1:0] EXE_DIV   = ALUOP_W'(8'b00011010);
    localparam logic [ALUOP_W-1:0] EXE_DIVU  = ALUOP_W'(8'b00011011);
    localparam logic [ALUOP_W-1:0] EXE_MFHI  = ALUOP_W'(8'b00010000);
    localparam logic [ALUOP_W-1:0] EXE_MTHI  = ALUOP_W'(8'b00010001);
    localparam logic [ALUOP_W-1:0] EXE_MFLO  = ALUOP_W'(8'b00010010);
    localparam logic [ALUOP_W-1:0] EXE_MTLO  = ALUOP_W'(8'b00010011);

    localparam logic [ALUSEL_W-1:0] RES_LOGIC = ALUSEL_W'(3'b001);
    localparam logic [ALUSEL_W-1:0] RES_SHIFT = ALUSEL_W'(3'b010);
    localparam logic [ALUSEL_W-1:0] RES_MOVE  = ALUSEL_W'(3'b011);
    localparam logic [ALUSEL_W-1:0] RES_ARITH = ALUSEL_W'(3'b100);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   hi, lo;
    logic [DATA_W-1:0]   quot, rem, dvsr, dvnd_raw;
    logic                neg_q, neg_r, div0;

    logic                is_div, is_sdiv, is_mult, is_mthi, is_mtlo, no_wb;
    logic [SH_W-1:0]     shamt;
    logic [DATA_W-1:0]   sum, diff, res, a_mag, b_mag;
    logic                ovf_add, ovf_sub, ovf;
    logic [2*DATA_W-1:0] ext1, ext2, prod;
    logic [DATA_W:0]     shifted, trial;

    assign is_sdiv = aluop_in == EXE_DIV;
    assign is_div  = is_sdiv || aluop_in == EXE_DIVU;
    assign is_mult = aluop_in == EXE_MULT || aluop_in == EXE_MULTU;
    assign is_mthi = aluop_in == EXE_MTHI;
    assign is_mtlo = aluop_in == EXE_MTLO;
    assign no_wb   = is_div || is_mult || is_mthi || is_mtlo;

    assign shamt = reg1_in[SH_W-1:0];
    assign sum   = reg1_in + reg2_in;
    assign diff  = reg1_in - reg2_in;

    assign ovf_add = (reg1_in[DATA_W-1] == reg2_in[DATA_W-1])
                  && (sum[DATA_W-1] != reg1_in[DATA_W-1]);
    assign ovf_sub = (reg1_in[DATA_W-1] != reg2_in[DATA_W-1])
                  && (diff[DATA_W-1] != reg1_in[DATA_W-1]);
    assign ovf = alusel_in == RES_ARITH
              && ((aluop_in == EXE_ADD && ovf_add)
               || (aluop_in == EXE_SUB && ovf_sub));

    // Sign-extend only for MULT; a 2W x 2W product truncated to 2W is exact
    assign ext1 = {{DATA_W{aluop_in == EXE_MULT && reg1_in[DATA_W-1]}}, reg1_in};
    assign ext2 = {{DATA_W{aluop_in == EXE_MULT && reg2_in[DATA_W-1]}}, reg2_in};
    assign prod = ext1 * ext2;

    assign a_mag = (is_sdiv && reg1_in[DATA_W-1]) ? -reg1_in : reg1_in;
    assign b_mag = (is_sdiv && reg2_in[DATA_W-1]) ? -reg2_in : reg2_in;

    assign shifted = {rem, quot[DATA_W-1]};
    assign trial   = shifted - {1'b0, dvsr};

    always_comb begin
        res = '0;
        case (alusel_in)
            RES_LOGIC: begin
                case (aluop_in)
                    EXE_OR:  res = reg1_in | reg2_in;
                    EXE_AND: res = reg1_in & reg2_in;
                    EXE_XOR: res = reg1_in ^ reg2_in;
                    EXE_NOR: res = ~(reg1_in | reg2_in);
                    default: res = '0;
                endcase
            end
            RES_SHIFT: begin
                case (aluop_in)
                    EXE_SLL: res = reg2_in << shamt;
                    EXE_SRL: res = reg2_in >> shamt;
                    EXE_SRA: res = $unsigned($signed(reg2_in) >>> shamt);
                    default: res = '0;
                endcase
            end
            RES_ARITH: begin
                case (aluop_in)
                    EXE_ADD, EXE_ADDU: res = sum;
                    EXE_SUB, EXE_SUBU: res = diff;
                    EXE_SLT:  res = {{(DATA_W-1){1'b0}},
                                     $signed(reg1_in) < $signed(reg2_in)};
                    EXE_SLTU: res = {{(DATA_W-1){1'b0}}, reg1_in < reg2_in};
                    default:  res = '0;
                endcase
            end
            RES_MOVE: begin
                case (aluop_in)
                    EXE_MFHI: res = hi;
                    EXE_MFLO: res = lo;
                    default:  res = '0;
                endcase
            end
            default: res = '0;
        endcase
    end

    assign w_reg_addr_out = rst_n ? w_reg_addr_in : '0;
    assign w_reg_data_out = rst_n ? res : '0;
    assign w_reg_en_out   = rst_n && w_reg_en_in && !ovf && !no_wb;
    assign ovf_out        = rst_n && ovf;
    assign stall_req      = rst_n && !flush
                         && ((state == IDLE && is_div) || state == BUSY);
    assign hi_out         = hi;
    assign lo_out         = lo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            quot     <= '0;
            rem      <= '0;
            dvsr     <= '0;
            dvnd_raw <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div0     <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (is_div) begin
                        quot     <= a_mag;
                        rem      <= '0;
                        dvsr     <= b_mag;
                        dvnd_raw <= reg1_in;
                        neg_q    <= is_sdiv && (reg1_in[DATA_W-1] ^ reg2_in[DATA_W-1]);
                        neg_r    <= is_sdiv && reg1_in[DATA_W-1];
                        div0     <= reg2_in == '0;
                        cnt      <= '0;
                        state    <= (reg2_in == '0) ? DONE : BUSY;
                    end else if (is_mult) begin
                        {hi, lo} <= prod;
                    end else if (is_mthi) begin
                        hi <= reg1_in;
                    end else if (is_mtlo) begin
                        lo <= reg1_in;
                    end
                end
                BUSY: begin
                    if (!trial[DATA_W]) begin
                        rem  <= trial[DATA_W-1:0];
                        quot <= {quot[DATA_W-2:0], 1'b1};
                    end else begin
                        rem  <= shifted[DATA_W-1:0];
                        quot <= {quot[DATA_W-2:0], 1'b0};
                    end
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    hi    <= div0 ? dvnd_raw : (neg_r ? -rem : rem);
                    lo    <= div0 ? '1 : (neg_q ? -quot : quot);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Directed bench for ex_muldiv_stage: ALU ops, HI/LO moves, multiply,
// divide timing/results, flush and synchronous reset behaviour.
module tb_ex_muldiv_stage;

    localparam logic [7:0] EXE_AND   = 8'b00100100;
    localparam logic [7:0] EXE_OR    = 8'b00100101;
    localparam logic [7:0] EXE_XOR   = 8'b00100110;
    localparam logic [7:0] EXE_NOR   = 8'b00100111;
    localparam logic [7:0] EXE_SLL   = 8'b01111100;
    localparam logic [7:0] EXE_SRL   = 8'b00000010;
    localparam logic [7:0] EXE_SRA   = 8'b00000011;
    localparam logic [7:0] EXE_SLT   = 8'b00101010;
    localparam logic [7:0] EXE_SLTU  = 8'b00101011;
    localparam logic [7:0] EXE_ADD   = 8'b00100000;
    localparam logic [7:0] EXE_ADDU  = 8'b00100001;
    localparam logic [7:0] EXE_SUB   = 8'b00100010;
    localparam logic [7:0] EXE_SUBU  = 8'b00100011;
    localparam logic [7:0] EXE_MULT  = 8'b00011000;
    localparam logic [7:0] EXE_MULTU = 8'b00011001;
    localparam logic [7:0] EXE_DIV   = 8'b00011010;
    localparam logic [7:0] EXE_DIVU  = 8'b00011011;
    localparam logic [7:0] EXE_MFHI  = 8'b00010000;
    localparam logic [7:0] EXE_MTHI  = 8'b00010001;
    localparam logic [7:0] EXE_MFLO  = 8'b00010010;
    localparam logic [7:0] EXE_NOP   = 8'b00000000;

    localparam logic [2:0] RES_NOP   = 3'b000;
    localparam logic [2:0] RES_LOGIC = 3'b001;
    localparam logic [2:0] RES_SHIFT = 3'b010;
    localparam logic [2:0] RES_MOVE  = 3'b011;
    localparam logic [2:0] RES_ARITH = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic [2:0]  alusel_in;
    logic [7:0]  aluop_in;
    logic [31:0] reg1_in, reg2_in;
    logic [4:0]  w_reg_addr_in, w_reg_addr_out;
    logic        w_reg_en_in, w_reg_en_out;
    logic [31:0] w_reg_data_out, hi_out, lo_out;
    logic        ovf_out, stall_req;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ex_muldiv_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alusel_in(alusel_in), .aluop_in(aluop_in),
        .reg1_in(reg1_in), .reg2_in(reg2_in),
        .w_reg_addr_in(w_reg_addr_in), .w_reg_en_in(w_reg_en_in),
        .w_reg_addr_out(w_reg_addr_out), .w_reg_data_out(w_reg_data_out),
        .w_reg_en_out(w_reg_en_out), .ovf_out(ovf_out),
        .stall_req(stall_req), .hi_out(hi_out), .lo_out(lo_out)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] sel, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        alusel_in     = sel;
        aluop_in      = op;
        reg1_in       = a;
        reg2_in       = b;
        w_reg_addr_in = 5'd3;
        w_reg_en_in   = 1'b1;
    endtask

    task automatic comb(input string tag, input logic [2:0] sel,
                        input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_data,
                        input logic exp_en, input logic exp_ovf);
        drive(sel, op, a, b);
        @(negedge clk);
        check({tag, "_data"}, w_reg_data_out, exp_data);
        check({tag, "_en"}, w_reg_en_out, exp_en);
        check({tag, "_ovf"}, ovf_out, exp_ovf);
        step();
    endtask

    // Issue a divide, count stall cycles, then check HI/LO after commit.
    task automatic run_div(input string tag, input logic [7:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input int exp_stalls, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        drive(RES_NOP, op, a, b);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (stall_req) begin
                n++;
                step();
            end else begin
                done = 1'b1;
            end
        end
        check({tag, "_no_timeout"}, done, 1);
        check({tag, "_stalls"}, n, exp_stalls);
        step();
        check({tag, "_hi"}, hi_out, exp_hi);
        check({tag, "_lo"}, lo_out, exp_lo);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drive(RES_SHIFT, EXE_SLL, 32'd5, 32'h0000FFF0);
        @(negedge clk);
        check("rst_data", w_reg_data_out, 0);
        check("rst_en", w_reg_en_out, 0);
        check("rst_addr", w_reg_addr_out, 0);
        check("rst_stall", stall_req, 0);
        step();
        step();
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);
        rst_n = 1'b1;

        drive(RES_SHIFT, EXE_SLL, 32'd5, 32'h0000FFF0);
        @(negedge clk);
        check("sll_addr", w_reg_addr_out, 3);
        check("sll_stall", stall_req, 0);
        step();
        comb("sll", RES_SHIFT, EXE_SLL, 32'd5, 32'h0000FFF0, 32'h001FFE00, 1, 0);
        comb("srl", RES_SHIFT, EXE_SRL, 32'd4, 32'h80000000, 32'h08000000, 1, 0);
        comb("sra", RES_SHIFT, EXE_SRA, 32'd4, 32'h80000000, 32'hF8000000, 1, 0);
        comb("or",  RES_LOGIC, EXE_OR,  32'hF0F0, 32'h0F0F, 32'h0000FFFF, 1, 0);
        comb("and", RES_LOGIC, EXE_AND, 32'hF0F0, 32'hFF00, 32'h0000F000, 1, 0);
        comb("xor", RES_LOGIC, EXE_XOR, 32'hF0F0, 32'hFF00, 32'h00000FF0, 1, 0);
        comb("nor", RES_LOGIC, EXE_NOR, 32'h0, 32'h0, 32'hFFFFFFFF, 1, 0);
        comb("slt", RES_ARITH, EXE_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 1, 0);
        comb("sltu", RES_ARITH, EXE_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 0);
        comb("add_ovf", RES_ARITH, EXE_ADD, 32'h7FFFFFFF, 32'd1, 32'h80000000, 0, 1);
        comb("addu", RES_ARITH, EXE_ADDU, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1, 0);
        comb("add_ok", RES_ARITH, EXE_ADD, 32'd10, 32'hFFFFFFFD, 32'd7, 1, 0);
        comb("sub_ovf", RES_ARITH, EXE_SUB, 32'h80000000, 32'd1, 32'h7FFFFFFF, 0, 1);
        comb("subu", RES_ARITH, EXE_SUBU, 32'd5, 32'd7, 32'hFFFFFFFE, 1, 0);
        comb("nop", RES_NOP, EXE_NOP, 32'd5, 32'd7, 32'h0, 1, 0);

        comb("mult", RES_NOP, EXE_MULT, 32'hFFFFFFFD, 32'd7, 32'h0, 0, 0);
        check("mult_hi", hi_out, 32'hFFFFFFFF);
        check("mult_lo", lo_out, 32'hFFFFFFEB);
        comb("mflo", RES_MOVE, EXE_MFLO, 32'h0, 32'h0, 32'hFFFFFFEB, 1, 0);
        comb("multu", RES_NOP, EXE_MULTU, 32'hFFFFFFFF, 32'd2, 32'h0, 0, 0);
        comb("mfhi", RES_MOVE, EXE_MFHI, 32'h0, 32'h0, 32'h00000001, 1, 0);
        check("multu_lo", lo_out, 32'hFFFFFFFE);

        run_div("div_neg", EXE_DIV, 32'hFFFFFFF9, 32'd2, 33,
                32'hFFFFFFFF, 32'hFFFFFFFD);
        run_div("div_minneg", EXE_DIV, 32'h80000000, 32'hFFFFFFFF, 33,
                32'h00000000, 32'h80000000);
        run_div("divu_zero", EXE_DIVU, 32'd7, 32'd0, 1,
                32'h00000007, 32'hFFFFFFFF);

        drive(RES_NOP, EXE_DIV, 32'd100, 32'd3);
        step();
        for (int i = 0; i < 9; i++) step();
        flush = 1'b1;
        @(negedge clk);
        check("flush_stall", stall_req, 0);
        step();
        flush = 1'b0;
        drive(RES_NOP, EXE_NOP, 32'd0, 32'd0);
        @(negedge clk);
        check("flush_idle", stall_req, 0);
        check("flush_hi", hi_out, 32'h00000007);
        check("flush_lo", lo_out, 32'hFFFFFFFF);
        step();

        flush = 1'b1;
        drive(RES_NOP, EXE_MTHI, 32'h1234, 32'd0);
        step();
        flush = 1'b0;
        check("mthi_flush", hi_out, 32'h00000007);
        comb("mthi", RES_NOP, EXE_MTHI, 32'h1234, 32'd0, 32'h0, 0, 0);
        check("mthi_hi", hi_out, 32'h00001234);

        drive(RES_NOP, EXE_DIV, 32'd100, 32'd3);
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0;
        @(negedge clk);
        check("rstdiv_stall", stall_req, 0);
        step();
        check("rstdiv_hi", hi_out, 0);
        check("rstdiv_lo", lo_out, 0);
        rst_n = 1'b1;
        run_div("divu_9_4", EXE_DIVU, 32'd9, 32'd4, 33, 32'd1, 32'd2);
        drive(RES_NOP, EXE_NOP, 32'd0, 32'd0);
        @(negedge clk);
        check("final_idle", stall_req, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
